id_stage_pipe: RTL and testbench

//  Registered, parametrised instruction-decode stage between IF and EX of the MIPS-subset pipeline
//  (R-type, lw, sw, beq). Decodes, reads the register file, resolves beq in ID, and drives an ID/EX

---
 rtl/id_pkg.sv | 41 ++++
 rtl/id_hazard_unit.sv | 50 +++++
 rtl/id_stage_pipe.sv | 113 +++++++++++
 tb/tb_id_stage_pipe.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// id_pkg: opcodes, FSM states, forward selects and decoded controls shared by the ID stage
package id_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;

   localparam logic [1:0] FWD_RF  = 2'd0;
   localparam logic [1:0] FWD_MEM = 2'd1;
   localparam logic [1:0] FWD_EX  = 2'd2;

   typedef enum logic {RUN, SQUASH} state_t;

   typedef struct packed {
      logic load;
      logic is_rtype;
      logic mem_read;
      logic mem_write;
      logic writes;
      logic is_beq;
      logic uses_rs;
      logic uses_rt;
   } ctrl_t;

   // load marks instructions that occupy the ID/EX register; beq and unknown opcodes never do
   function automatic ctrl_t decode(input logic [5:0] op);
      ctrl_t c;
      c = '0;
      c.is_rtype  = op == OP_RTYPE;
      c.mem_read  = op == OP_LW;
      c.mem_write = op == OP_SW;
      c.is_beq    = op == OP_BEQ;
      c.load      = c.is_rtype | c.mem_read | c.mem_write;
      c.writes    = c.is_rtype | c.mem_read;
      c.uses_rs   = c.load | c.is_beq;
      c.uses_rt   = c.is_rtype | c.mem_write | c.is_beq;
      return c;
   endfunction

endpackage

// File: rtl/id_hazard_unit.sv
// id_hazard_unit: source/destination compare giving the ID stall and operand forward selects (ID_FWD_EN)
module id_hazard_unit
   import id_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic              check,
   input  logic              uses_rs,
   input  logic              uses_rt,
   input  logic              is_beq,
   input  logic [REG_AW-1:0] rs,
   input  logic [REG_AW-1:0] rt,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_reg_write,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_reg_write,
   output logic              hz_stall,
   output logic [1:0]        fwd_rs,
   output logic [1:0]        fwd_rt
);

   logic ex_src, load_use, ex_hit;

   assign ex_src   = ex_rd != '0 && ((uses_rs && ex_rd == rs) || (uses_rt && ex_rd == rt));
   assign load_use = ex_mem_read && ex_src;
   assign ex_hit   = ex_reg_write && ex_src;

`ifdef ID_FWD_EN
   // a load result is not ready in EX, so only ALU results are forwarded from there
   function automatic logic [1:0] pick(input logic [REG_AW-1:0] a);
      return a == '0 ? FWD_RF :
             (ex_reg_write && !ex_mem_read && ex_rd == a) ? FWD_EX :
             (mem_reg_write && mem_rd == a) ? FWD_MEM : FWD_RF;
   endfunction

   assign hz_stall = check && (load_use || (is_beq && ex_hit));
   assign fwd_rs   = pick(rs);
   assign fwd_rt   = pick(rt);
`else
   logic mem_hit;

   assign mem_hit  = mem_reg_write && mem_rd != '0 &&
                     ((uses_rs && mem_rd == rs) || (uses_rt && mem_rd == rt));
   assign hz_stall = check && (load_use || ex_hit || mem_hit);
   assign fwd_rs   = FWD_RF;
   assign fwd_rt   = FWD_RF;
`endif

endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: MIPS-subset decode stage with ID/EX register, hazard stall and beq squash (ID_FWD_EN adds forwarding)
module id_stage_pipe
   import id_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_valid,
   input  logic [31:0]       if_instr,
   output logic              if_ready,
   output logic [REG_AW-1:0] rs,
   output logic [REG_AW-1:0] rt,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
   input  logic              ex_ready,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_reg_write,
   input  logic              ex_mem_read,
   input  logic [DATA_W-1:0] ex_result,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_reg_write,
   input  logic [DATA_W-1:0] mem_result,
   output logic              id_valid,
   output logic [5:0]        id_opcode,
   output logic [5:0]        id_funct,
   output logic [REG_AW-1:0] id_rd,
   output logic [DATA_W-1:0] id_imm,
   output logic [DATA_W-1:0] id_rs_data,
   output logic [DATA_W-1:0] id_rt_data,
   output logic              id_mem_read,
   output logic              id_mem_write,
   output logic              id_reg_write,
   output logic              br_taken,
   output logic [DATA_W-1:0] br_offset
);

   ctrl_t             c;
   state_t            state;
   logic              hz_stall, load_ok, xfer, squash_now, take, fill;
   logic [1:0]        fwd_rs, fwd_rt;
   logic [DATA_W-1:0] a, b, imm;
   logic [REG_AW-1:0] dest;

   assign c    = decode(if_instr[31:26]);
   assign rs   = if_instr[21 +: REG_AW];
   assign rt   = if_instr[16 +: REG_AW];
   assign dest = c.is_rtype ? if_instr[11 +: REG_AW] : rt;
   assign imm  = DATA_W'($signed(if_instr[15:0]));

   id_hazard_unit #(.REG_AW(REG_AW)) u_hazard (
      .check        (if_valid && state == RUN),
      .uses_rs      (c.uses_rs),
      .uses_rt      (c.uses_rt),
      .is_beq       (c.is_beq),
      .rs           (rs),
      .rt           (rt),
      .ex_rd        (ex_rd),
      .ex_reg_write (ex_reg_write),
      .ex_mem_read  (ex_mem_read),
      .mem_rd       (mem_rd),
      .mem_reg_write(mem_reg_write),
      .hz_stall     (hz_stall),
      .fwd_rs       (fwd_rs),
      .fwd_rt       (fwd_rt)
   );

   assign a = fwd_rs == FWD_EX ? ex_result : fwd_rs == FWD_MEM ? mem_result : rs_data;
   assign b = fwd_rt == FWD_EX ? ex_result : fwd_rt == FWD_MEM ? mem_result : rt_data;

   assign squash_now = state == SQUASH;
   assign load_ok    = !id_valid || ex_ready;
   assign if_ready   = !hz_stall && load_ok;
   assign xfer       = if_valid && if_ready;
   assign take       = xfer && !squash_now && c.is_beq && a == b;
   assign fill       = xfer && !squash_now && c.load;

   // squash FSM, branch pulse and ID/EX register: load on transfer, bubble when free, hold when EX is blocked
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state        <= RUN;
         br_taken     <= 1'b0;
         br_offset    <= '0;
         id_valid     <= 1'b0;
         id_opcode    <= '0;
         id_funct     <= '0;
         id_rd        <= '0;
         id_imm       <= '0;
         id_rs_data   <= '0;
         id_rt_data   <= '0;
         id_mem_read  <= 1'b0;
         id_mem_write <= 1'b0;
         id_reg_write <= 1'b0;
      end else begin
         br_taken  <= take;
         br_offset <= take ? imm : '0;
         if (xfer) state <= take ? SQUASH : RUN;
         if (load_ok) begin
            id_valid     <= fill;
            id_opcode    <= fill ? if_instr[31:26] : '0;
            id_funct     <= fill && c.is_rtype ? if_instr[5:0] : '0;
            id_rd        <= fill ? dest : '0;
            id_imm       <= fill && !c.is_rtype ? imm : '0;
            id_rs_data   <= fill ? a : '0;
            id_rt_data   <= fill && c.uses_rt ? b : '0;
            id_mem_read  <= fill && c.mem_read;
            id_mem_write <= fill && c.mem_write;
            id_reg_write <= fill && c.writes && dest != '0;
         end
      end

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed scenarios plus a randomized run against a behavioural decode/hazard model
module tb_id_stage_pipe;
   import id_pkg::*;

`ifdef ID_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0, reset = 1'b0;
   logic        if_valid, if_ready, ex_ready, ex_reg_write, ex_mem_read, mem_reg_write;
   logic [31:0] if_instr, rs_data, rt_data, ex_result, mem_result;
   logic [4:0]  rs, rt, ex_rd, mem_rd;
   logic        id_valid, id_mem_read, id_mem_write, id_reg_write, br_taken;
   logic [5:0]  id_opcode, id_funct;
   logic [4:0]  id_rd;
   logic [31:0] id_imm, id_rs_data, id_rt_data, br_offset;
   logic [149:0] outs;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   assign outs = {id_valid, id_opcode, id_funct, id_rd, id_imm, id_rs_data, id_rt_data,
                  id_mem_read, id_mem_write, id_reg_write, br_taken, br_offset};

   id_stage_pipe #(.DATA_W(32), .REG_AW(5)) dut (
      .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_ready(if_ready),
      .rs(rs), .rt(rt), .rs_data(rs_data), .rt_data(rt_data), .ex_ready(ex_ready),
      .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_result(ex_result),
      .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
      .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct), .id_rd(id_rd),
      .id_imm(id_imm), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
      .br_taken(br_taken), .br_offset(br_offset)
   );

   function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] s, input logic [4:0] t,
                                         input logic [5:0] fn);
      return {OP_RTYPE, s, t, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                                         input logic [15:0] im);
      return {op, s, t, im};
   endfunction

   // operand a correct ID stage delivers for register r given the current pipeline state
   function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] rf);
      if (FWD && r != 0 && ex_reg_write && !ex_mem_read && ex_rd == r) return ex_result;
      if (FWD && r != 0 && mem_reg_write && mem_rd == r) return mem_result;
      return rf;
   endfunction

   task automatic idle();
      if_valid = 0; if_instr = 0; rs_data = 0; rt_data = 0; ex_ready = 1;
      ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0; ex_result = 0;
      mem_rd = 0; mem_reg_write = 0; mem_result = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle(); if_valid = 1; if_instr = rtype(3, 1, 2, 6'h20); rs_data = 5; rt_data = 6;
      tick();
      checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL rst_pre id_valid got %b exp 1", id_valid); end
      #2 reset = 0; #1;
      checks++; if (outs !== '0) begin errors++; $display("FAIL rst_clear outs got %h exp 0", outs); end
      idle(); @(posedge clk); #3 reset = 1; #1;
      checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", if_ready); end
      if_valid = 1; if_instr = itype(OP_BEQ, 1, 2, 16'hFFFD); rs_data = 7; rt_data = 7;
      tick();
      checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL rst_beq br_taken got %b exp 1", br_taken); end
      #2 reset = 0; #2 reset = 1;
      if_instr = rtype(8, 1, 2, 6'h20);
      tick();
      checks++; if ({id_valid, id_rd, br_taken} !== {1'b1, 5'd8, 1'b0}) begin errors++;
         $display("FAIL rst_nosquash got %b/%0d/%b exp 1/8/0", id_valid, id_rd, br_taken); end
   endtask

   task automatic test_stall_hold();
      logic [149:0] held;
      idle(); if_valid = 1; if_instr = rtype(3, 1, 2, 6'h20); rs_data = 11; rt_data = 22;
      tick();
      checks++;
      if ({id_valid, id_rd, id_funct, id_rs_data, id_rt_data, id_reg_write} !==
          {1'b1, 5'd3, 6'h20, 32'd11, 32'd22, 1'b1}) begin errors++;
         $display("FAIL hold_load got %b %0d %h %0d %0d %b", id_valid, id_rd, id_funct, id_rs_data, id_rt_data, id_reg_write); end
      held = outs;
      ex_ready = 0; if_instr = rtype(7, 5, 6, 6'h22); rs_data = 33; rt_data = 44;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d] got %b exp 0", k, if_ready); end
         tick();
         checks++; if (outs !== held) begin errors++; $display("FAIL hold_stable[%0d] got %h exp %h", k, outs, held); end
      end
      ex_ready = 1; #1;
      checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL hold_release got %b exp 1", if_ready); end
      tick();
      checks++; if ({id_valid, id_rd, id_funct, id_rs_data} !== {1'b1, 5'd7, 6'h22, 32'd33}) begin errors++;
         $display("FAIL hold_next got %b %0d %h %0d exp 1 7 22 33", id_valid, id_rd, id_funct, id_rs_data); end
   endtask

   task automatic test_load_use();
      idle(); if_valid = 1; if_instr = rtype(5, 4, 2, 6'h20); rs_data = 1; rt_data = 2;
      ex_rd = 4; ex_reg_write = 1; ex_mem_read = 1; #1;
      checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL lu_stall got %b exp 0", if_ready); end
      tick();
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got %b exp 0", id_valid); end
      ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0; mem_rd = 4; mem_reg_write = 1; mem_result = 55; #1;
`ifdef ID_FWD_EN
      checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL lu_one_cycle got %b exp 1", if_ready); end
      tick();
      checks++; if ({id_valid, id_rs_data, id_rt_data} !== {1'b1, 32'd55, 32'd2}) begin errors++;
         $display("FAIL lu_fwd_mem got %b %0d %0d exp 1 55 2", id_valid, id_rs_data, id_rt_data); end
`else
      checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL lu_mem_stall got %b exp 0", if_ready); end
      tick();
      mem_reg_write = 0; #1;
      checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL lu_release got %b exp 1", if_ready); end
      tick();
      checks++; if ({id_valid, id_rs_data} !== {1'b1, 32'd1}) begin errors++;
         $display("FAIL lu_decode got %b %0d exp 1 1", id_valid, id_rs_data); end
`endif
   endtask

   task automatic test_branch();
      idle(); if_valid = 1; if_instr = itype(OP_BEQ, 1, 2, 16'hFFFD); rs_data = 7; rt_data = 7; #1;
      checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL br_ready got %b exp 1", if_ready); end
      tick();
      checks++; if ({br_taken, br_offset, id_valid} !== {1'b1, 32'hFFFFFFFD, 1'b0}) begin errors++;
         $display("FAIL br_taken got %b %h %b exp 1 fffffffd 0", br_taken, br_offset, id_valid); end
      if_instr = rtype(9, 1, 2, 6'h20); rs_data = 1; rt_data = 2; #1;
      checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL br_sq_ready got %b exp 1", if_ready); end
      tick();
      checks++; if ({br_taken, br_offset, id_valid} !== 34'd0) begin errors++;
         $display("FAIL br_squash got %b %h %b exp 0 0 0", br_taken, br_offset, id_valid); end
      if_instr = rtype(10, 1, 2, 6'h20);
      tick();
      checks++; if ({id_valid, id_rd} !== {1'b1, 5'd10}) begin errors++; $display("FAIL br_after got %b %0d exp 1 10", id_valid, id_rd); end
      if_instr = itype(OP_BEQ, 1, 2, 16'd5); rs_data = 3; rt_data = 4;
      tick();
      checks++; if ({br_taken, br_offset, id_valid} !== 34'd0) begin errors++;
         $display("FAIL br_nottaken got %b %h %b exp 0 0 0", br_taken, br_offset, id_valid); end
      if_instr = rtype(11, 1, 2, 6'h20);
      tick();
      checks++; if ({id_valid, id_rd} !== {1'b1, 5'd11}) begin errors++; $display("FAIL br_nt_next got %b %0d exp 1 11", id_valid, id_rd); end
      if_instr = itype(OP_BEQ, 1, 2, 16'd5); rs_data = 4; rt_data = 4; ex_rd = 2; ex_reg_write = 1; #1;
      checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL br_ex_stall got %b exp 0", if_ready); end
      tick();
      checks++; if ({br_taken, id_valid} !== 2'b00) begin errors++; $display("FAIL br_ex_hold got %b %b exp 0 0", br_taken, id_valid); end
      ex_reg_write = 0; #1;
      checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL br_ex_clear got %b exp 1", if_ready); end
      tick();
      checks++; if ({br_taken, br_offset} !== {1'b1, 32'd5}) begin errors++; $display("FAIL br_late got %b %h exp 1 5", br_taken, br_offset); end
      if_instr = rtype(12, 1, 2, 6'h20);
      tick();
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL br_late_squash got %b exp 0", id_valid); end
   endtask

   task automatic test_forward();
      idle(); if_valid = 1; if_instr = rtype(6, 1, 0, 6'h20); ex_rd = 1; ex_reg_write = 1; ex_result = 9; #1;
`ifdef ID_FWD_EN
      checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL fwd_nostall got %b exp 1", if_ready); end
      tick();
      checks++; if ({id_valid, id_rs_data} !== {1'b1, 32'd9}) begin errors++; $display("FAIL fwd_ex got %b %0d exp 1 9", id_valid, id_rs_data); end
      mem_rd = 1; mem_reg_write = 1; mem_result = 3;
      tick();
      checks++; if (id_rs_data !== 32'd9) begin errors++; $display("FAIL fwd_prio got %0d exp 9", id_rs_data); end
      ex_reg_write = 0;
      tick();
      checks++; if (id_rs_data !== 32'd3) begin errors++; $display("FAIL fwd_mem got %0d exp 3", id_rs_data); end
`else
      checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL nofwd_ex_stall got %b exp 0", if_ready); end
      tick();
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL nofwd_bubble got %b exp 0", id_valid); end
      ex_reg_write = 0; mem_rd = 1; mem_reg_write = 1; #1;
      checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL nofwd_mem_stall got %b exp 0", if_ready); end
      tick();
      mem_reg_write = 0; #1;
      checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL nofwd_clear got %b exp 1", if_ready); end
      tick();
      checks++; if ({id_valid, id_rs_data} !== {1'b1, 32'd0}) begin errors++; $display("FAIL nofwd_rf got %b %0d exp 1 0", id_valid, id_rs_data); end
`endif
      idle(); if_valid = 1; if_instr = rtype(6, 0, 0, 6'h20); rs_data = 21;
      ex_reg_write = 1; ex_mem_read = 1; mem_reg_write = 1; ex_result = 9; mem_result = 3; #1;
      checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL r0_nostall got %b exp 1", if_ready); end
      tick();
      checks++; if (id_rs_data !== 32'd21) begin errors++; $display("FAIL r0_nofwd got %0d exp 21", id_rs_data); end
   endtask

   task automatic test_bubble();
      idle(); if_valid = 1; if_instr = {6'h3F, 26'h123456}; #1;
      checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL unk_ready got %b exp 1", if_ready); end
      tick();
      checks++; if ({id_valid, id_opcode} !== 7'd0) begin errors++; $display("FAIL unk_bubble got %b %h exp 0 0", id_valid, id_opcode); end
      if_instr = rtype(0, 1, 2, 6'h20);
      tick();
      checks++; if ({id_valid, id_reg_write} !== 2'b10) begin errors++; $display("FAIL rd0 got %b %b exp 1 0", id_valid, id_reg_write); end
      if_instr = itype(OP_LW, 1, 4, 16'h8004); rs_data = 100; rt_data = 99;
      tick();
      checks++;
      if ({id_valid, id_opcode, id_rd, id_imm, id_mem_read, id_mem_write, id_reg_write, id_rs_data, id_rt_data} !==
          {1'b1, 6'h23, 5'd4, 32'hFFFF8004, 3'b101, 32'd100, 32'd0}) begin errors++;
         $display("FAIL lw_decode got %b %h %0d %h %b%b%b %0d %0d", id_valid, id_opcode, id_rd, id_imm,
                  id_mem_read, id_mem_write, id_reg_write, id_rs_data, id_rt_data); end
      if_instr = itype(OP_SW, 2, 5, 16'h0010); rs_data = 7; rt_data = 77;
      tick();
      checks++;
      if ({id_valid, id_opcode, id_rd, id_imm, id_mem_read, id_mem_write, id_reg_write, id_rs_data, id_rt_data} !==
          {1'b1, 6'h2B, 5'd5, 32'h10, 3'b010, 32'd7, 32'd77}) begin errors++;
         $display("FAIL sw_decode got %b %h %0d %h %b%b%b %0d %0d", id_valid, id_opcode, id_rd, id_imm,
                  id_mem_read, id_mem_write, id_reg_write, id_rs_data, id_rt_data); end
   endtask

   task automatic test_random();
      logic [116:0] e_id;
      logic         e_bt;
      logic [31:0]  e_bo;
      bit           sq;
      idle(); reset = 0; #2 reset = 1;
      e_id = '0; e_bt = 0; e_bo = '0; sq = 0;
      for (int i = 0; i < 400; i++) begin
         logic [5:0]  op;
         logic [4:0]  fs, ft, fd, dst;
         logic [31:0] va, vb, im;
         bit known, urt, body, src_ex, src_mem, stall, ready, xfer;
         case ($urandom_range(0, 5))
            0, 1: op = OP_RTYPE;
            2: op = OP_LW;
            3: op = OP_SW;
            4: op = OP_BEQ;
            default: op = 6'h3F;
         endcase
         fs = 5'($urandom_range(0, 3)); ft = 5'($urandom_range(0, 3)); fd = 5'($urandom_range(0, 3));
         if_instr = {op, fs, ft, fd, 5'($urandom), 6'($urandom)};
         if_valid = $urandom_range(0, 3) != 0;
         ex_ready = $urandom_range(0, 3) != 0;
         rs_data = $urandom_range(0, 1); rt_data = $urandom_range(0, 1);
         ex_rd = 5'($urandom_range(0, 3)); ex_reg_write = $urandom_range(0, 2) == 0;
         ex_mem_read = ex_reg_write && $urandom_range(0, 1) == 1; ex_result = $urandom;
         mem_rd = 5'($urandom_range(0, 3)); mem_reg_write = $urandom_range(0, 2) == 0; mem_result = $urandom;
         known   = op == OP_RTYPE || op == OP_LW || op == OP_SW || op == OP_BEQ;
         body    = op == OP_RTYPE || op == OP_LW || op == OP_SW;
         urt     = op == OP_RTYPE || op == OP_SW || op == OP_BEQ;
         src_ex  = known && ex_rd != 0 && (ex_rd == fs || (urt && ex_rd == ft));
         src_mem = known && mem_rd != 0 && (mem_rd == fs || (urt && mem_rd == ft));
         stall   = if_valid && !sq && ((ex_mem_read && src_ex) ||
                   (FWD ? (op == OP_BEQ && ex_reg_write && src_ex) : ((ex_reg_write && src_ex) || (mem_reg_write && src_mem))));
         ready   = !stall && (!e_id[116] || ex_ready);
         va = operand(fs, rs_data); vb = operand(ft, rt_data);
         im = {{16{if_instr[15]}}, if_instr[15:0]};
         dst = op == OP_RTYPE ? fd : ft;
         #1;
         checks++; if ({if_ready, rs, rt} !== {ready, fs, ft}) begin errors++;
            $display("FAIL rnd_comb[%0d] got %b %0d %0d exp %b %0d %0d", i, if_ready, rs, rt, ready, fs, ft); end
         xfer = if_valid && ready;
         e_bt = xfer && !sq && op == OP_BEQ && va == vb;
         e_bo = e_bt ? im : 32'd0;
         if (!e_id[116] || ex_ready)
            e_id = (xfer && !sq && body) ?
                   {1'b1, op, op == OP_RTYPE ? if_instr[5:0] : 6'd0, dst, op == OP_RTYPE ? 32'd0 : im, va,
                    op == OP_LW ? 32'd0 : vb, op == OP_LW, op == OP_SW, op != OP_SW && dst != 0} : '0;
         if (xfer) sq = !sq && e_bt;
         tick();
         checks++; if (outs !== {e_id, e_bt, e_bo}) begin errors++;
            $display("FAIL rnd_out[%0d] got %h exp %h", i, outs, {e_id, e_bt, e_bo}); end
      end
   endtask

   initial begin
      idle();
      reset = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1;
      test_reset();
      test_stall_hold();
      test_load_use();
      test_branch();
      test_forward();
      test_bubble();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
